// File: rtl/mul_share_sched.sv
// ============================================================================
// mul_share_sched : round-robin shared shift-add multiplier with early exit
// Rev 1.0
// ============================================================================
`default_nettype none

module mul_share_sched #(
  parameter int NREQ = 2,
  parameter int W    = 32,
  parameter int CW   = $clog2(W) + 1,
  localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid_i,
  input  logic [NREQ*W-1:0]   req_a_i,
  input  logic [NREQ*W-1:0]   req_b_i,
  output logic [NREQ-1:0]     req_ready_o,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [IDW-1:0]      resp_id_o,
  output logic [W-1:0]        resp_res_o,
  output logic [CW-1:0]       resp_cycles_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    acc_q;
  logic [CW-1:0]   cnt_q;
  logic [IDW-1:0]  resp_id_q;
  logic [W-1:0]    resp_res_q;
  logic [CW-1:0]   resp_cycles_q;

  logic            w_found;
  logic [IDW-1:0]  w_win;
  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;
  logic            w_swap;
  logic [W-1:0]    w_addend;
  int              w_idx;

  // Walk from farthest to nearest so the requester closest after rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_a     = '0;
    w_b     = '0;
    w_idx   = 0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = int'(rr_ptr_q) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (req_valid_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = IDW'(w_idx);
        w_a     = req_a_i[w_idx*W +: W];
        w_b     = req_b_i[w_idx*W +: W];
      end
    end
  end

  // A 0/1 operand moved into b lets the multiply finish in a single step.
  assign w_swap   = (w_a <= W'(1)) && (w_b > W'(1));
  assign w_addend = a_q & {W{b_q[0]}};

  // Gated by rst_n so no handshake can complete while reset is held.
  assign req_ready_o   = (state_q == S_IDLE && w_found && rst_n) ? (NREQ'(1) << w_win) : '0;
  assign resp_valid_o  = (state_q == S_DONE);
  assign busy_o        = (state_q != S_IDLE);
  assign resp_id_o     = resp_id_q;
  assign resp_res_o    = resp_res_q;
  assign resp_cycles_o = resp_cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= IDW'(NREQ - 1);
      a_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      resp_id_q     <= '0;
      resp_res_q    <= '0;
      resp_cycles_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_found) begin
            a_q      <= w_swap ? w_b : w_a;
            b_q      <= w_swap ? w_a : w_b;
            rr_ptr_q <= w_win;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= S_BUSY;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q + CW'(1);
          if (b_q <= W'(1)) begin
            resp_res_q    <= acc_q + w_addend;
            resp_id_q     <= rr_ptr_q;
            resp_cycles_q <= cnt_q + CW'(1);
            state_q       <= S_DONE;
          end else begin
            acc_q <= acc_q + w_addend;
            a_q   <= {a_q[W-2:0], 1'b0};
            b_q   <= {1'b0, b_q[W-1:1]};
          end
        end
        S_DONE: begin
          if (resp_ready_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
